// File: rtl/pointwise_add_seq_if.sv
// pointwise_add_seq_if: operand, length and result bundle for the sequential pointwise adder
`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif
interface pointwise_add_seq_if #(
   parameter int N = `MAX_NEURONS,
   parameter int WIDTH = 32,
   parameter int LW = $clog2(N+1)
);
   logic start;
   logic [LW-1:0] length;
   logic [N-1:0][WIDTH-1:0] vector1;
   logic [N-1:0][WIDTH-1:0] vector2;
   logic [N-1:0][WIDTH-1:0] out;
   logic busy;
   logic done;
   logic overflow;
   modport master (output start, length, vector1, vector2, input out, busy, done, overflow);
   modport slave (input start, length, vector1, vector2, output out, busy, done, overflow);
endinterface

// File: rtl/pointwise_add_seq.sv
// pointwise_add_seq: sequential saturating element-wise signed adder, one element per clock
`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif
module pointwise_add_seq #(
   parameter int N = `MAX_NEURONS,
   parameter int WIDTH = 32,
   parameter int LW = $clog2(N+1)
) (
   input logic clk,
   input logic rst_n,
   pointwise_add_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [N-1:0][WIDTH-1:0] v1, v2, out_r;
   logic [LW-1:0] len, idx, eff;
   logic [WIDTH-1:0] a, b, sat;
   logic [WIDTH:0] s;
   logic busy_r, done_r, ovf_r, accept, clamp, last;
   assign accept = bus.start && state != RUN;
   assign eff = bus.length > LW'(N) ? LW'(N) : bus.length;
   assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
   assign clamp = s[WIDTH] ^ s[WIDTH-1];
   assign sat = clamp ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
   assign last = ({1'b0, idx} + (LW+1)'(1)) >= {1'b0, len};
   assign bus.out = out_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.overflow = ovf_r;
   // select the latched operand pair addressed by idx
   always_comb begin
      a = '0;
      b = '0;
      for (int k = 0; k < N; k++) begin
         a = idx == LW'(k) ? v1[k] : a;
         b = idx == LW'(k) ? v2[k] : b;
      end
   end
   // control FSM and result registers; L == 0 still spends one RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         v1 <= '0;
         v2 <= '0;
         out_r <= '0;
         len <= '0;
         idx <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         state <= RUN;
         v1 <= bus.vector1;
         v2 <= bus.vector2;
         out_r <= '0;
         len <= eff;
         idx <= '0;
         busy_r <= 1'b1;
         done_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (state == RUN) begin
         if (idx < len) begin
            for (int k = 0; k < N; k++)
               if (idx == LW'(k)) out_r[k] <= sat;
            ovf_r <= ovf_r | clamp;
            idx <= idx + LW'(1);
         end
         if (last) begin
            state <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end else begin
         state <= IDLE;
         done_r <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pointwise_add_seq.sv
// tb_pointwise_add_seq: directed bench with a per-cycle behavioural reference model
module tb_pointwise_add_seq;
   localparam int N = 8, W = 32, LW = $clog2(N+1);
   typedef logic [N-1:0][W-1:0] arr_t;
   logic clk = 0, rst_n = 1;
   int tests = 0, fails = 0;
   pointwise_add_seq_if #(.N(N), .WIDTH(W)) bus ();
   pointwise_add_seq #(.N(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // reference: j counts clock edges since the last accepted start
   bit active = 0, chk_en = 0;
   int j = 0, len_m = 0;
   logic [W-1:0] m_sum [N];
   bit m_clamp [N];
   logic in_run;
   assign in_run = active && j < (len_m > 0 ? len_m : 1);
   function automatic logic [W:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
      longint s = longint'($signed(x)) + longint'($signed(y));
      longint hi = (longint'(1) << (W-1)) - 1;
      longint lo = -(longint'(1) << (W-1));
      if (s > hi) return {1'b1, W'(hi)};
      if (s < lo) return {1'b1, W'(lo)};
      return {1'b0, W'(s)};
   endfunction
   function automatic arr_t model_out();
      arr_t e = '0;
      int m = j < len_m ? j : len_m;
      for (int k = 0; k < N; k++) if (active && k < m) e[k] = m_sum[k];
      return e;
   endfunction
   function automatic logic model_ovf();
      logic o = 0;
      int m = j < len_m ? j : len_m;
      for (int k = 0; k < N; k++) if (active && k < m) o = o | m_clamp[k];
      return o;
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) active <= 0;
      else if (bus.start && !in_run) begin
         active <= 1;
         j <= 0;
         len_m <= int'(bus.length) > N ? N : int'(bus.length);
         for (int k = 0; k < N; k++) {m_clamp[k], m_sum[k]} <= sat_add(bus.vector1[k], bus.vector2[k]);
      end else if (active) j <= j + 1;
   task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // cycle-by-cycle comparison against the reference model
   always @(negedge clk)
      if (rst_n && chk_en) begin
         chk("model_out", bus.out, model_out());
         chk("model_busy", bus.busy, in_run);
         chk("model_done", bus.done, active && j == (len_m > 0 ? len_m : 1));
         chk("model_ovf", bus.overflow, model_ovf());
      end
   task automatic run(input arr_t x, input arr_t y, input int len, input bit glitch, output int bcnt);
      bit seen = 0;
      arr_t g;
      for (int k = 0; k < N; k++) g[k] = W'(1000 + k);
      @(negedge clk);
      bus.vector1 = x;
      bus.vector2 = y;
      bus.length = LW'(len);
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      bcnt = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (bus.done) seen = 1;
         else begin
            bcnt += int'(bus.busy);
            bus.start = glitch && t == 2;
            if (glitch && t == 2) begin
               bus.vector1 = g;
               bus.vector2 = g;
            end
            @(negedge clk);
         end
      end
      bus.start = 0;
      chk("done_seen", seen, 1);
   endtask
   initial begin
      arr_t x, y;
      int bc, d1, d2, nd;
      bus.start = 0;
      bus.length = '0;
      bus.vector1 = '0;
      bus.vector2 = '0;
      #1 rst_n = 0;
      #1;
      chk("rst_out", bus.out, 0);
      chk("rst_flags", {bus.busy, bus.done, bus.overflow}, 0);
      @(negedge clk);
      #2 rst_n = 1;
      chk_en = 1;
      for (int k = 0; k < N; k++) begin x[k] = W'(k); y[k] = W'(10 * k); end
      run(x, y, 8, 0, bc);
      chk("basic_busy_cycles", bc, 8);
      chk("basic_out1", bus.out[1], 11);
      chk("basic_out7", bus.out[7], 77);
      chk("basic_ovf", bus.overflow, 0);
      x = '0;
      y = '0;
      x[0] = 32'h7FFFFFFF; y[0] = 32'h1;
      x[1] = 32'h80000000; y[1] = 32'hFFFFFFFF;
      x[2] = 32'h5; y[2] = 32'hFFFFFFFD;
      run(x, y, 8, 0, bc);
      chk("sat_pos", bus.out[0], 32'h7FFFFFFF);
      chk("sat_neg", bus.out[1], 32'h80000000);
      chk("sat_plain", bus.out[2], 2);
      chk("sat_ovf", bus.overflow, 1);
      repeat (3) @(negedge clk);
      chk("sat_ovf_hold", bus.overflow, 1);
      chk("sat_out_hold", bus.out[0], 32'h7FFFFFFF);
      for (int k = 0; k < N; k++) begin x[k] = W'(k + 1); y[k] = '0; end
      run(x, y, 3, 0, bc);
      chk("len3_busy_cycles", bc, 3);
      chk("len3_out2", bus.out[2], 3);
      chk("len3_out3", bus.out[3], 0);
      run(x, x, 0, 0, bc);
      chk("len0_busy_cycles", bc, 1);
      chk("len0_out", bus.out, 0);
      for (int k = 0; k < N; k++) begin x[k] = W'(k); y[k] = W'(k); end
      run(x, y, N + 5, 0, bc);
      chk("lenbig_busy_cycles", bc, 8);
      chk("lenbig_out7", bus.out[7], 14);
      for (int k = 0; k < N; k++) begin x[k] = W'(k); y[k] = W'(1); end
      run(x, y, 8, 1, bc);
      chk("ignore_out5", bus.out[5], 6);
      chk("ignore_busy_cycles", bc, 8);
      for (int k = 0; k < N; k++) begin x[k] = W'(100); y[k] = W'(k); end
      @(negedge clk);
      bus.vector1 = x;
      bus.vector2 = y;
      bus.length = LW'(3);
      bus.start = 1;
      d1 = -1;
      d2 = -1;
      for (int t = 0; t < 30 && d2 < 0; t++) begin
         @(negedge clk);
         if (bus.done) begin
            if (d1 < 0) d1 = t; else d2 = t;
         end
      end
      bus.start = 0;
      chk("b2b_spacing", d2 - d1, 4);
      chk("b2b_out2", bus.out[2], 102);
      x = '0;
      y = '0;
      x[0] = 32'h7FFFFFFF; y[0] = 32'h1;
      @(negedge clk);
      bus.vector1 = x;
      bus.vector2 = y;
      bus.length = LW'(8);
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      repeat (3) @(negedge clk);
      chk("pre_rst_ovf", bus.overflow, 1);
      #1 rst_n = 0;
      #1;
      chk("midrun_rst_out", bus.out, 0);
      chk("midrun_rst_flags", {bus.busy, bus.done, bus.overflow}, 0);
      #1 rst_n = 1;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         nd += int'(bus.done);
      end
      chk("midrun_no_done", nd, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
